// File: rtl/demux4_trunc_if.sv
// Handshake bundle for the 1-to-4 narrowing demultiplexer: one 8-bit
// source port and four sink ports of 4, 6, 7 and 8 bits.
interface demux4_trunc_if;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;

    logic [3:0] a_data;
    logic [5:0] b_data;
    logic [6:0] c_data;
    logic [7:0] d_data;
    logic       a_valid;
    logic       b_valid;
    logic       c_valid;
    logic       d_valid;
    logic       a_ready;
    logic       b_ready;
    logic       c_ready;
    logic       d_ready;

    // Producer and sink side (drives source word, accepts channel words).
    modport master (
        output in_data, in_sel, in_valid,
        input  in_ready,
        input  a_data, b_data, c_data, d_data,
        input  a_valid, b_valid, c_valid, d_valid,
        output a_ready, b_ready, c_ready, d_ready
    );

    // Demultiplexer side.
    modport slave (
        input  in_data, in_sel, in_valid,
        output in_ready,
        output a_data, b_data, c_data, d_data,
        output a_valid, b_valid, c_valid, d_valid,
        input  a_ready, b_ready, c_ready, d_ready
    );
endinterface

// File: rtl/demux4_trunc.sv
// Registered 1-to-4 demultiplexer. Each sink owns a one-entry register;
// the source is stalled only by the selected channel. Words narrowed with
// non-zero upper bits raise a one-cycle trunc pulse and bump a saturating
// counter, but are still delivered with their low bits.
module demux4_trunc #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    demux4_trunc_if.slave    bus,
    output logic             trunc,
    output logic [CNT_W-1:0] trunc_cnt
);

    logic [3:0]       a_data_r;
    logic [5:0]       b_data_r;
    logic [6:0]       c_data_r;
    logic [7:0]       d_data_r;
    logic [3:0]       valid_r;      // bit 0 = a ... bit 3 = d
    logic             trunc_r;
    logic [CNT_W-1:0] cnt_r;

    logic [3:0]       ready_s;
    logic [3:0]       load_s;
    logic [3:0]       drain_s;
    logic             sel_full_s;
    logic             sel_ready_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             lost_s;

    // True when narrowing the word for the given channel drops a set bit.
    function automatic logic lost_bits(input logic [7:0] data, input logic [1:0] sel);
        logic lost;
        case (sel)
            2'b00:   lost = |data[7:4];
            2'b01:   lost = |data[7:6];
            2'b10:   lost = data[7];
            2'b11:   lost = 1'b0;
            default: lost = 1'b0;
        endcase
        return lost;
    endfunction

    // Source handshake, per-channel load/drain strobes and truncation detect.
    always_comb begin
        ready_s     = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
        sel_full_s  = valid_r[bus.in_sel];
        sel_ready_s = ready_s[bus.in_sel];
        in_ready_s  = ~rst & (~sel_full_s | sel_ready_s);
        accept_s    = bus.in_valid & in_ready_s;
        load_s      = 4'b0000;
        if (accept_s) begin
            load_s[bus.in_sel] = 1'b1;
        end else begin
            load_s = 4'b0000;
        end
        drain_s = valid_r & ready_s;
        lost_s  = accept_s & lost_bits(bus.in_data, bus.in_sel);
    end

    // Channel full flags: a load wins over a same-cycle drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 4'b0000;
        end else begin
            valid_r <= load_s | (valid_r & ~drain_s);
        end
    end

    // Channel data registers change only when their channel loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data_r <= 4'h0;
            b_data_r <= 6'h00;
            c_data_r <= 7'h00;
            d_data_r <= 8'h00;
        end else begin
            if (load_s[0]) a_data_r <= bus.in_data[3:0];
            if (load_s[1]) b_data_r <= bus.in_data[5:0];
            if (load_s[2]) c_data_r <= bus.in_data[6:0];
            if (load_s[3]) d_data_r <= bus.in_data[7:0];
        end
    end

    // Truncation pulse and saturating counter; the pulse keeps firing after saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trunc_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            trunc_r <= lost_s;
            if (lost_s && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.a_data   = a_data_r;
    assign bus.b_data   = b_data_r;
    assign bus.c_data   = c_data_r;
    assign bus.d_data   = d_data_r;
    assign bus.a_valid  = valid_r[0];
    assign bus.b_valid  = valid_r[1];
    assign bus.c_valid  = valid_r[2];
    assign bus.d_valid  = valid_r[3];
    assign trunc        = trunc_r;
    assign trunc_cnt    = cnt_r;

endmodule

// File: tb/tb_demux4_trunc.sv
// Directed bench for demux4_trunc: reset, routing/narrowing, truncation,
// backpressure, drain-and-load streaming, idle inputs and counter saturation.
module tb_demux4_trunc;

    logic       clk;
    logic       rst;
    logic       trunc;
    logic [7:0] trunc_cnt;
    logic       trunc2;
    logic [1:0] trunc_cnt2;
    int         n_checks;
    int         n_fail;

    demux4_trunc_if bus ();
    demux4_trunc_if bus2 ();

    demux4_trunc #(.CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .trunc     (trunc),
        .trunc_cnt (trunc_cnt)
    );

    demux4_trunc #(.CNT_W(2)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .trunc     (trunc2),
        .trunc_cnt (trunc_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, zero-extended data} of channel k of the main DUT
    function automatic logic [8:0] chan(input int k);
        case (k)
            0:       return {bus.a_valid, 4'h0, bus.a_data};
            1:       return {bus.b_valid, 2'b00, bus.b_data};
            2:       return {bus.c_valid, 1'b0, bus.c_data};
            default: return {bus.d_valid, bus.d_data};
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sel = 2'b00; bus.in_data = 8'h00;
        bus.a_ready = 1'b0; bus.b_ready = 1'b1; bus.c_ready = 1'b1; bus.d_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_sel = 2'b00; bus2.in_data = 8'h00;
        bus2.a_ready = 1'b1; bus2.b_ready = 1'b1; bus2.c_ready = 1'b1; bus2.d_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        n_checks++; if (trunc_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_cnt: got %h want 00", trunc_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", bus.in_ready); end
        // park a word in channel a, then reset mid-cycle
        bus.in_data = 8'h0A; bus.in_sel = 2'b00; bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        n_checks++; if (chan(0) !== 9'h10A) begin n_fail++; $display("FAIL pre_rst_a: got %h want 10a", chan(0)); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (chan(0) !== 9'h000) begin n_fail++; $display("FAIL async_rst_a: got %h want 000", chan(0)); end
        n_checks++; if ({bus.b_valid, bus.c_valid, bus.d_valid, trunc} !== 4'b0000) begin n_fail++; $display("FAIL async_rst_valids: got %b want 0000", {bus.b_valid, bus.c_valid, bus.d_valid, trunc}); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b want 0", bus.in_ready); end
        cyc();
        rst = 1'b0;
        bus.a_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_routing();
        logic [7:0] din  [4] = '{8'h0A, 8'h2B, 8'h5C, 8'hFF};
        logic [8:0] want [4] = '{9'h10A, 9'h12B, 9'h15C, 9'h1FF};
        for (int i = 0; i < 4; i++) begin
            bus.in_data = din[i]; bus.in_sel = 2'(i); bus.in_valid = 1'b1;
            cyc();
            n_checks++; if (chan(i) !== want[i]) begin n_fail++; $display("FAIL route_ch%0d: got %h want %h", i, chan(i), want[i]); end
            n_checks++; if (trunc !== 1'b0) begin n_fail++; $display("FAIL route_trunc%0d: got %b want 0", i, trunc); end
        end
        bus.in_valid = 1'b0;
        cyc();
        n_checks++; if (chan(3) !== 9'h0FF) begin n_fail++; $display("FAIL route_drain_d: got %h want 0ff", chan(3)); end
    endtask

    task automatic test_truncation();
        logic [7:0] din  [4] = '{8'hF3, 8'hC1, 8'h80, 8'h80};
        logic [8:0] want [4] = '{9'h103, 9'h101, 9'h100, 9'h180};
        logic       wt   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] wc   [4] = '{8'd1, 8'd2, 8'd3, 8'd3};
        for (int i = 0; i < 4; i++) begin
            bus.in_data = din[i]; bus.in_sel = 2'(i); bus.in_valid = 1'b1;
            cyc();
            n_checks++; if (chan(i) !== want[i]) begin n_fail++; $display("FAIL trunc_data%0d: got %h want %h", i, chan(i), want[i]); end
            n_checks++; if (trunc !== wt[i]) begin n_fail++; $display("FAIL trunc_pulse%0d: got %b want %b", i, trunc, wt[i]); end
            n_checks++; if (trunc_cnt !== wc[i]) begin n_fail++; $display("FAIL trunc_cnt%0d: got %0d want %0d", i, trunc_cnt, wc[i]); end
        end
        bus.in_valid = 1'b0;
        cyc();
        n_checks++; if (trunc !== 1'b0) begin n_fail++; $display("FAIL trunc_idle: got %b want 0", trunc); end
    endtask

    task automatic test_backpressure();
        bus.b_ready = 1'b0;
        bus.in_data = 8'h11; bus.in_sel = 2'b01; bus.in_valid = 1'b1;
        cyc();
        n_checks++; if (chan(1) !== 9'h111) begin n_fail++; $display("FAIL bp_hold: got %h want 111", chan(1)); end
        bus.in_data = 8'h22;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %b want 0", bus.in_ready); end
        cyc();
        n_checks++; if (chan(1) !== 9'h111) begin n_fail++; $display("FAIL bp_stable: got %h want 111", chan(1)); end
        bus.in_data = 8'h05; bus.in_sel = 2'b00;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_ready: got %b want 1", bus.in_ready); end
        cyc();
        n_checks++; if (chan(0) !== 9'h105) begin n_fail++; $display("FAIL bp_other_data: got %h want 105", chan(0)); end
        bus.in_data = 8'h22; bus.in_sel = 2'b01; bus.b_ready = 1'b1;
        #1;
        n_checks++; if ({bus.in_ready, chan(1)} !== 10'h311) begin n_fail++; $display("FAIL bp_release: got %h want 311", {bus.in_ready, chan(1)}); end
        cyc();
        bus.in_valid = 1'b0;
        n_checks++; if (chan(1) !== 9'h122) begin n_fail++; $display("FAIL bp_reload: got %h want 122", chan(1)); end
        cyc();
        n_checks++; if (chan(1) !== 9'h022) begin n_fail++; $display("FAIL bp_drained: got %h want 022", chan(1)); end
    endtask

    task automatic test_back_to_back();
        bus.d_ready = 1'b1; bus.in_sel = 2'b11; bus.in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_data = 8'(i);
            cyc();
            n_checks++; if (chan(3) !== (9'h100 | 9'(i))) begin n_fail++; $display("FAIL b2b_d%0d: got %h want %h", i, chan(3), 9'h100 | 9'(i)); end
        end
        bus.in_valid = 1'b0;
        cyc();
        n_checks++; if (chan(3) !== 9'h008) begin n_fail++; $display("FAIL b2b_end: got %h want 008", chan(3)); end
    endtask

    task automatic test_idle_inputs();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_sel = 2'(i); bus.in_data = 8'hF0 | 8'(i);
            cyc();
            n_checks++; if ({bus.a_valid, bus.b_valid, bus.c_valid, bus.d_valid, trunc} !== 5'b00000) begin n_fail++; $display("FAIL idle%0d: got %b want 00000", i, {bus.a_valid, bus.b_valid, bus.c_valid, bus.d_valid, trunc}); end
        end
        n_checks++; if (trunc_cnt !== 8'd3) begin n_fail++; $display("FAIL idle_cnt: got %0d want 3", trunc_cnt); end
    endtask

    task automatic test_saturation();
        logic [1:0] wc [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus2.in_data = 8'hF0; bus2.in_sel = 2'b00; bus2.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++; if (trunc_cnt2 !== wc[i]) begin n_fail++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, trunc_cnt2, wc[i]); end
            n_checks++; if ({trunc2, bus2.a_valid, bus2.a_data} !== 6'b110000) begin n_fail++; $display("FAIL sat_pulse%0d: got %b want 110000", i, {trunc2, bus2.a_valid, bus2.a_data}); end
        end
        bus2.in_valid = 1'b0;
        cyc();
        n_checks++; if ({trunc2, trunc_cnt2} !== 3'b011) begin n_fail++; $display("FAIL sat_hold: got %b want 011", {trunc2, trunc_cnt2}); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_routing();
        test_truncation();
        test_backpressure();
        test_back_to_back();
        test_idle_inputs();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
